irq_arbiter: RTL

Interrupt arbiter between peripheral interrupt sources and the machine-mode privilege/CSR unit. It latches single-cycle interrupt pulses from NSRC external sources and one timer source, then selects one by fixed priority. It drives the privilege unit's eip/eip_istimer level request until eip_reply, and exposes a claim/complete register window on the memory-mapped bus so the trap handler can identify and retire the external source.

---
 rtl/irq_arbiter_pkg.sv | 26 ++
 rtl/irq_prio_enc.sv | 34 +++
 rtl/irq_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_arbiter_pkg
//  Purpose  : Shared constants for the interrupt arbiter: register offsets
//             (a[3:2] decode), FSM state encoding and source-ID width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package irq_arbiter_pkg;

    // Source IDs are 1..31; ID 0 means "no source".
    localparam int ID_W = 5;

    // Register word offsets, decoded from a[3:2].
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // Arbiter FSM encoding (also visible in STATUS[1:0]).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage : irq_arbiter_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : irq_prio_enc
//  Purpose  : Combinational lowest-index-first priority encoder. Returns the
//             1-based ID of the lowest set request bit.
//  Ports    : req   [NSRC-1:0] in  - request vector
//             valid            out - any request bit set
//             id    [ID_W-1:0] out - index+1 of winner, 0 when none
//  Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import irq_arbiter_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i + 1);
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : irq_arbiter
//  Purpose  : Latches external/timer interrupt pulses, picks one by fixed
//             priority (lowest external index first, then timer), and holds a
//             level request to the privilege unit until it is accepted.
//             A claim/complete register window lets the trap handler identify
//             and retire the external source being serviced.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             irq_in  [NSRC-1:0]   - external interrupt pulses
//             timer_irq            - timer interrupt pulse
//             a [3:0], d [31:0], we - register bus (a[3:2] decoded)
//             spo [31:0]           - combinational read data
//             eip, eip_istimer     - request level and its qualifier
//             eip_reply            - acceptance pulse
//  Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            timer_irq,
    input  logic [3:0]      a,
    input  logic [31:0]     d,
    input  logic            we,
    output logic [31:0]     spo,
    output logic            eip,
    output logic            eip_istimer,
    input  logic            eip_reply
);

    logic [1:0]      state_q,      state_d;
    logic [NSRC-1:0] pend_q,       pend_d;
    logic            tpend_q,      tpend_d;
    logic [NSRC-1:0] enable_q,     enable_d;
    logic            in_service_q, in_service_d;
    logic [ID_W-1:0] claim_id_q,   claim_id_d;
    logic [ID_W-1:0] sel_id_q,     sel_id_d;
    logic            sel_timer_q,  sel_timer_d;

    logic [NSRC-1:0] elig;
    logic            ext_valid;
    logic [ID_W-1:0] ext_id;
    logic            ack_fire;
    logic            unused_bus_bits;

    // Externals are blocked while a claimed source awaits completion.
    assign elig = pend_q & enable_q & {NSRC{~in_service_q}};

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .req   (elig),
        .valid (ext_valid),
        .id    (ext_id)
    );

    assign ack_fire    = (state_q == ST_REQ) && eip_reply;
    assign eip         = (state_q == ST_REQ);
    assign eip_istimer = (state_q == ST_REQ) && sel_timer_q;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        tpend_d      = tpend_q;
        enable_d     = enable_q;
        in_service_d = in_service_q;
        claim_id_d   = claim_id_q;
        sel_id_d     = sel_id_q;
        sel_timer_d  = sel_timer_q;

        case (state_q)
            // ACK already carries the post-acceptance pend/in_service values,
            // so it arbitrates like IDLE; this keeps the minimum inter-request
            // gap at exactly one low cycle.
            ST_IDLE, ST_ACK: begin
                if (ext_valid || tpend_q) begin
                    sel_id_d    = ext_valid ? ext_id : '0;
                    sel_timer_d = ~ext_valid;
                    state_d     = ST_REQ;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (eip_reply) begin
                    state_d = ST_ACK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (we && (a[3:2] == REG_ENABLE)) begin
            enable_d = d[NSRC-1:0];
        end

        // Completion compares against the claim held before this edge; a
        // simultaneous acceptance below then installs the new claim.
        if (we && (a[3:2] == REG_CLAIM) && in_service_q && (d[ID_W-1:0] == claim_id_q)) begin
            in_service_d = 1'b0;
        end

        if (ack_fire) begin
            if (sel_timer_q) begin
                tpend_d = 1'b0;
            end else begin
                for (int i = 0; i < NSRC; i++) begin
                    if (sel_id_q == ID_W'(i + 1)) begin
                        pend_d[i] = 1'b0;
                    end
                end
                in_service_d = 1'b1;
                claim_id_d   = sel_id_q;
            end
        end

        // New pulses are applied last so a set beats a same-cycle clear.
        pend_d = pend_d | irq_in;
        if (timer_irq) begin
            tpend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            tpend_q      <= 1'b0;
            enable_q     <= '0;
            in_service_q <= 1'b0;
            claim_id_q   <= '0;
            sel_id_q     <= '0;
            sel_timer_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            tpend_q      <= tpend_d;
            enable_q     <= enable_d;
            in_service_q <= in_service_d;
            claim_id_q   <= claim_id_d;
            sel_id_q     <= sel_id_d;
            sel_timer_q  <= sel_timer_d;
        end
    end

    always_comb begin
        spo = '0;
        case (a[3:2])
            REG_PENDING: spo = 32'(pend_q);
            REG_ENABLE:  spo = 32'(enable_q);
            REG_CLAIM:   spo = {in_service_q, 26'b0, claim_id_q};
            REG_STATUS:  spo = {29'b0, tpend_q, state_q};
            default:     spo = '0;
        endcase
    end

    // Byte-lane bits and write-data bits above the widest field are ignored.
    assign unused_bus_bits = ^{a[1:0], d};

endmodule : irq_arbiter
`default_nettype wire
